// File: rtl/segre_pkg.sv
// Shared types and constants for the segre data cache.
package segre_pkg;

   localparam int WORD_SIZE           = 32;
   localparam int DCACHE_LANE_SIZE    = 128;
   localparam int DCACHE_REFILL_BEATS = DCACHE_LANE_SIZE / WORD_SIZE;

   typedef enum logic [1:0] {
      REFILL_IDLE,
      REFILL_REQ,
      REFILL_WAIT,
      REFILL_WRITE
   } dcache_refill_state_e;

endpackage

// File: rtl/segre_dcache_refill.sv
// Dcache line-refill engine: fetches one lane as NUM_BEATS word beats from
// memory, assembles them little-endian in a lane buffer and writes the whole
// lane into the data array for a single cycle.
module segre_dcache_refill
   import segre_pkg::*;
#(
   parameter int LANE_SIZE = DCACHE_LANE_SIZE,
   parameter int BEAT_SIZE = WORD_SIZE,
   parameter int NUM_BEATS = LANE_SIZE / BEAT_SIZE
) (
   input  logic                 clk_i,
   input  logic                 rsn_i,
   input  logic                 miss_i,
   input  logic [WORD_SIZE-1:0] miss_addr_i,
   output logic                 refill_busy_o,
   output logic                 mem_req_o,
   output logic [WORD_SIZE-1:0] mem_addr_o,
   input  logic                 mem_gnt_i,
   input  logic                 mem_rvalid_i,
   input  logic [BEAT_SIZE-1:0] mem_rdata_i,
   output logic                 cache_wr_o,
   output logic [WORD_SIZE-1:0] cache_addr_o,
   output logic [LANE_SIZE-1:0] cache_lane_o,
   output logic                 refill_done_o
);

   localparam int CNT_W    = $clog2(NUM_BEATS) + 1;
   localparam int IDX_W    = $clog2(NUM_BEATS);
   localparam int BYTE_SH  = $clog2(BEAT_SIZE / 8);
   localparam logic [CNT_W-1:0]     LAST_BEAT = CNT_W'(NUM_BEATS - 1);
   localparam logic [WORD_SIZE-1:0] LANE_MASK = WORD_SIZE'(LANE_SIZE / 8 - 1);

   dcache_refill_state_e state_q, state_d;
   logic [CNT_W-1:0]     req_cnt_q, req_cnt_d;
   logic [CNT_W-1:0]     rcv_cnt_q, rcv_cnt_d;
   logic [WORD_SIZE-1:0] base_q, base_d;
   logic [LANE_SIZE-1:0] buffer_q, buffer_d;

   logic beat_ok;
   logic last_beat;

   // Next-state, beat collection and output decode (outputs depend on registers only).
   always_comb begin
      state_d       = state_q;
      req_cnt_d     = req_cnt_q;
      rcv_cnt_d     = rcv_cnt_q;
      base_d        = base_q;
      buffer_d      = buffer_q;
      refill_busy_o = 1'b0;
      mem_req_o     = 1'b0;
      mem_addr_o    = '0;
      cache_wr_o    = 1'b0;
      cache_addr_o  = '0;
      cache_lane_o  = '0;
      refill_done_o = 1'b0;

      // A response only counts when a granted beat is still outstanding.
      beat_ok   = mem_rvalid_i && (rcv_cnt_q != req_cnt_q);
      last_beat = beat_ok && (rcv_cnt_q == LAST_BEAT);

      if ((state_q == REFILL_REQ || state_q == REFILL_WAIT) && beat_ok) begin
         buffer_d[BEAT_SIZE*rcv_cnt_q[IDX_W-1:0] +: BEAT_SIZE] = mem_rdata_i;
         rcv_cnt_d = rcv_cnt_q + CNT_W'(1);
      end

      case (state_q)
         REFILL_IDLE: begin
            if (miss_i) begin
               base_d    = miss_addr_i & ~LANE_MASK;
               req_cnt_d = '0;
               rcv_cnt_d = '0;
               buffer_d  = '0;
               state_d   = REFILL_REQ;
            end
         end
         REFILL_REQ: begin
            refill_busy_o = 1'b1;
            mem_req_o     = 1'b1;
            mem_addr_o    = base_q + (WORD_SIZE'(req_cnt_q) << BYTE_SH);
            if (mem_gnt_i) begin
               req_cnt_d = req_cnt_q + CNT_W'(1);
               if (req_cnt_q == LAST_BEAT) begin
                  state_d = last_beat ? REFILL_WRITE : REFILL_WAIT;
               end
            end
         end
         REFILL_WAIT: begin
            refill_busy_o = 1'b1;
            if (last_beat) begin
               state_d = REFILL_WRITE;
            end
         end
         REFILL_WRITE: begin
            refill_busy_o = 1'b1;
            cache_wr_o    = 1'b1;
            refill_done_o = 1'b1;
            cache_addr_o  = base_q;
            cache_lane_o  = buffer_q;
            state_d       = REFILL_IDLE;
         end
         default: begin
            state_d = REFILL_IDLE;
         end
      endcase
   end

   // State, counters, latched base and lane buffer; synchronous active-low reset clears all.
   always_ff @(posedge clk_i) begin
      if (!rsn_i) begin
         state_q   <= REFILL_IDLE;
         req_cnt_q <= '0;
         rcv_cnt_q <= '0;
         base_q    <= '0;
         buffer_q  <= '0;
      end else begin
         state_q   <= state_d;
         req_cnt_q <= req_cnt_d;
         rcv_cnt_q <= rcv_cnt_d;
         base_q    <= base_d;
         buffer_q  <= buffer_d;
      end
   end

endmodule

// File: tb/tb_segre_dcache_refill.sv
// Directed bench for segre_dcache_refill with an in-order memory responder.
module tb_segre_dcache_refill;

   logic         clk_i = 1'b0;
   logic         rsn_i;
   logic         miss_i;
   logic [31:0]  miss_addr_i;
   logic         refill_busy_o;
   logic         mem_req_o;
   logic [31:0]  mem_addr_o;
   logic         mem_gnt_i;
   logic         mem_rvalid_i;
   logic [31:0]  mem_rdata_i;
   logic         cache_wr_o;
   logic [31:0]  cache_addr_o;
   logic [127:0] cache_lane_o;
   logic         refill_done_o;

   segre_dcache_refill dut (
      .clk_i         (clk_i),
      .rsn_i         (rsn_i),
      .miss_i        (miss_i),
      .miss_addr_i   (miss_addr_i),
      .refill_busy_o (refill_busy_o),
      .mem_req_o     (mem_req_o),
      .mem_addr_o    (mem_addr_o),
      .mem_gnt_i     (mem_gnt_i),
      .mem_rvalid_i  (mem_rvalid_i),
      .mem_rdata_i   (mem_rdata_i),
      .cache_wr_o    (cache_wr_o),
      .cache_addr_o  (cache_addr_o),
      .cache_lane_o  (cache_lane_o),
      .refill_done_o (refill_done_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int          rdy;
      logic [31:0] addr;
   } rsp_t;

   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   int          bad_cnt  = 0;
   int          rsp_delay   = 1;
   int          stall_beat  = -1;
   int          stall_left  = 0;
   rsp_t        pend[$];
   logic [31:0] req_addr_q[$];
   int          req_cyc_q[$];
   int          wr_cnt, wr_cyc, done_cnt;
   logic [31:0] wr_addr;
   logic [127:0] wr_lane;

   localparam logic [127:0] LANE_1040 = 128'h44444444_33333333_22222222_11111111;
   localparam logic [127:0] LANE_2000 = 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000;
   localparam logic [127:0] LANE_3010 = 128'h0000301C_00003018_00003014_00003010;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_1040: mem_word = 32'h11111111;
         32'h0000_1044: mem_word = 32'h22222222;
         32'h0000_1048: mem_word = 32'h33333333;
         32'h0000_104C: mem_word = 32'h44444444;
         default: begin
            if (a[31:12] == 20'h00002) mem_word = {16'hAAAA, 14'd0, a[3:2]};
            else                       mem_word = a;
         end
      endcase
   endfunction

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", tag, act, exp);
      end
   endtask

   // Record what the DUT shows in the current cycle.
   task automatic observe();
      if (mem_req_o) begin
         req_addr_q.push_back(mem_addr_o);
         req_cyc_q.push_back(cyc);
      end else if (mem_addr_o != 32'd0) begin
         bad_cnt++;
      end
      if (!cache_wr_o && (cache_addr_o != 32'd0 || cache_lane_o != 128'd0)) bad_cnt++;
      if (cache_wr_o != refill_done_o) bad_cnt++;
      if (cache_wr_o) begin
         wr_cnt++;
         wr_cyc  = cyc;
         wr_addr = cache_addr_o;
         wr_lane = cache_lane_o;
      end
      if (refill_done_o) done_cnt++;
   endtask

   // Drive the memory side for the current cycle, then advance one clock.
   task automatic step();
      rsp_t r;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'd0;
      if (pend.size() > 0 && pend[0].rdy <= cyc) begin
         r = pend.pop_front();
         mem_rvalid_i = 1'b1;
         mem_rdata_i  = mem_word(r.addr);
      end
      if (mem_req_o && stall_beat >= 0 && int'(mem_addr_o[3:2]) == stall_beat && stall_left > 0) begin
         mem_gnt_i = 1'b0;
         stall_left--;
      end else begin
         mem_gnt_i = 1'b1;
      end
      if (mem_req_o && mem_gnt_i) pend.push_back('{cyc + rsp_delay, mem_addr_o});
      @(posedge clk_i);
      #1;
      cyc++;
   endtask

   // Run one refill with miss asserted at cycle 0; returns at the cycle after WRITE, undriven.
   task automatic run_refill(input logic [31:0] addr, input int chg_cyc);
      int timed_out;
      timed_out = 1;
      req_addr_q.delete();
      req_cyc_q.delete();
      wr_cnt = 0; wr_cyc = -1; done_cnt = 0; wr_addr = '0; wr_lane = '0;
      cyc = 0;
      miss_i = 1'b1;
      miss_addr_i = addr;
      for (int k = 0; k < 40; k++) begin
         observe();
         if (wr_cnt > 0 && cyc == wr_cyc + 1) begin
            timed_out = 0;
            break;
         end
         if (cyc == chg_cyc)     miss_addr_i = 32'h0000_5000;
         if (cyc == chg_cyc + 1) miss_i = 1'b0;
         if (cyc == chg_cyc + 2) miss_i = 1'b1;
         step();
      end
      check("refill_timeout", 128'(timed_out), 128'd0);
      miss_i = 1'b0;
   endtask

   initial begin
      rsn_i = 1'b0; miss_i = 1'b0; miss_addr_i = '0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_ctrl", {124'd0, refill_busy_o, mem_req_o, cache_wr_o, refill_done_o}, 128'd0);
      check("rst_mem_addr", 128'(mem_addr_o), 128'd0);
      check("rst_cache_addr", 128'(cache_addr_o), 128'd0);
      check("rst_lane", cache_lane_o, 128'd0);
      rsn_i = 1'b1;
      step();

      // 1: basic refill, grant every cycle, rvalid one cycle later
      run_refill(32'h0000_1046, -10);
      check("t1_req_cnt", 128'(req_addr_q.size()), 128'd4);
      if (req_addr_q.size() == 4) begin
         check("t1_addr0", 128'(req_addr_q[0]), 128'h1040);
         check("t1_addr1", 128'(req_addr_q[1]), 128'h1044);
         check("t1_addr2", 128'(req_addr_q[2]), 128'h1048);
         check("t1_addr3", 128'(req_addr_q[3]), 128'h104C);
         check("t1_req_first", 128'(req_cyc_q[0]), 128'd1);
         check("t1_req_last", 128'(req_cyc_q[3]), 128'd4);
      end
      check("t1_wr_cyc", 128'(wr_cyc), 128'd6);
      check("t1_cache_addr", 128'(wr_addr), 128'h1040);
      check("t1_lane", wr_lane, LANE_1040);
      check("t1_done_cnt", 128'(done_cnt), 128'd1);
      check("t1_idle_c7", {126'd0, refill_busy_o, cache_wr_o}, 128'd0);
      step();

      // 2: grant withheld for 3 cycles on beat 1
      stall_beat = 1; stall_left = 3;
      run_refill(32'h0000_1046, -10);
      stall_beat = -1;
      check("t2_req_cnt", 128'(req_addr_q.size()), 128'd7);
      if (req_addr_q.size() == 7) begin
         check("t2_hold_a", 128'(req_addr_q[1]), 128'h1044);
         check("t2_hold_b", 128'(req_addr_q[4]), 128'h1044);
         check("t2_after", 128'(req_addr_q[5]), 128'h1048);
      end
      check("t2_wr_cyc", 128'(wr_cyc), 128'd9);
      check("t2_lane", wr_lane, LANE_1040);
      step();

      // 3: responses two cycles after grant, grants back to back
      rsp_delay = 2;
      run_refill(32'h0000_301F, -10);
      check("t3_req_cnt", 128'(req_addr_q.size()), 128'd4);
      check("t3_wr_cyc", 128'(wr_cyc), 128'd7);
      check("t3_cache_addr", 128'(wr_addr), 128'h3010);
      check("t3_lane", wr_lane, LANE_3010);
      check("t3_done_cnt", 128'(done_cnt), 128'd1);
      rsp_delay = 1;
      step();

      // 4: miss_i / miss_addr_i disturbed while busy
      run_refill(32'h0000_1046, 2);
      check("t4_req_cnt", 128'(req_addr_q.size()), 128'd4);
      check("t4_cache_addr", 128'(wr_addr), 128'h1040);
      check("t4_lane", wr_lane, LANE_1040);
      check("t4_done_cnt", 128'(done_cnt), 128'd1);
      step(); step();
      check("t4_no_extra_req", {126'd0, mem_req_o, refill_busy_o}, 128'd0);

      // 5: reset in WAIT after two beats, then a clean refill at 0x2000
      rsp_delay = 3;
      cyc = 0;
      miss_i = 1'b1; miss_addr_i = 32'h0000_1046;
      for (int k = 0; k < 6; k++) begin
         observe();
         step();
      end
      check("t5_in_wait", {126'd0, refill_busy_o, mem_req_o}, 128'h2);
      rsn_i = 1'b0; miss_i = 1'b0;
      step();
      pend.delete();
      check("t5_rst_ctrl", {124'd0, refill_busy_o, mem_req_o, cache_wr_o, refill_done_o}, 128'd0);
      check("t5_rst_mem_addr", 128'(mem_addr_o), 128'd0);
      check("t5_rst_cache_addr", 128'(cache_addr_o), 128'd0);
      check("t5_rst_lane", cache_lane_o, 128'd0);
      rsn_i = 1'b1;
      rsp_delay = 1;
      run_refill(32'h0000_2000, -10);
      check("t5_wr_cyc", 128'(wr_cyc), 128'd6);
      check("t5_cache_addr", 128'(wr_addr), 128'h2000);
      check("t5_lane", wr_lane, LANE_2000);
      step();

      // 6: spurious rvalid while idle, then back-to-back refills
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
      @(posedge clk_i);
      #1;
      cyc++;
      mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      check("t6_idle_rvalid", {126'd0, refill_busy_o, mem_req_o}, 128'd0);
      run_refill(32'h0000_3010, -10);
      check("t6_lane", wr_lane, LANE_3010);
      check("t6_wr_cyc", 128'(wr_cyc), 128'd6);
      run_refill(32'h0000_2004, -10);
      check("t6_chain_req_first", 128'(req_cyc_q.size() > 0 ? req_cyc_q[0] : -1), 128'd1);
      check("t6_chain_addr", 128'(wr_addr), 128'h2000);
      check("t6_chain_lane", wr_lane, LANE_2000);
      check("t6_chain_done", 128'(done_cnt), 128'd1);
      step();

      check("protocol", 128'(bad_cnt), 128'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
